// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing arbiter: funct3 codes, widths,
// the per-requester operation record and flattened-bus slice helpers.
package alu_share_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam int IDX_W   = 2;

    localparam logic [2:0] FUNCT3_ADD = 3'b000;
    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_AND = 3'b010;
    localparam logic [2:0] FUNCT3_OR  = 3'b011;
    localparam logic [2:0] FUNCT3_XOR = 3'b100;
    localparam logic [2:0] FUNCT3_SR  = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      funct3;
        logic            funct7;
    } alu_op_t;

    // Low bit of element idx inside a flattened bus of w-bit elements.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SR);
    endfunction

    // Shifts only honour the low SHAMT_W bits of operand B.
    function automatic logic [XLEN-1:0] condition_b(input logic [2:0] funct3,
                                                    input logic [XLEN-1:0] b);
        return is_shift(funct3) ? {{(XLEN-SHAMT_W){1'b0}}, b[SHAMT_W-1:0]} : b;
    endfunction

endpackage

// File: rtl/alu_share_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr,
// wrapping past N-1 back to 0.
module rr_arbiter
    import alu_share_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    function automatic int wrap(input int x);
        return (x >= N) ? x - N : x;
    endfunction

    // NOTE: every output gets a default before the search loop, otherwise the
    // paths that find no eligible requester would infer latches.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_grant && eligible[wrap(int'(rr_ptr) + k)]) begin
                grant[wrap(int'(rr_ptr) + k)] = 1'b1;
                grant_idx                     = IDX_W'(wrap(int'(rr_ptr) + k));
                any_grant                     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// operand drive with shift masking, one-entry response slot per requester.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*XLEN-1:0]  req_a,
    input  logic [NUM_REQ*XLEN-1:0]  req_b,
    input  logic [NUM_REQ*3-1:0]     req_funct3,
    input  logic [NUM_REQ-1:0]       req_funct7,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [NUM_REQ*XLEN-1:0]  rsp_result,
    output logic [NUM_REQ*TAG_W-1:0] rsp_tag,
    output logic [XLEN-1:0]          alu_a,
    output logic [XLEN-1:0]          alu_b,
    output logic [2:0]               alu_funct3,
    output logic                     alu_funct7,
    input  logic [XLEN-1:0]          alu_result,
    output logic                     alu_busy,
    output logic [IDX_W-1:0]         grant_id,
    output logic [31:0]              conflict_cnt
);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic               any_grant;
    logic               conflict;
    alu_op_t            sel_op;

    // A slot that is draining this cycle can already take the next result.
    assign eligible = req_valid & (~rsp_valid | rsp_ready);
    assign conflict = ($countones(eligible) >= 2);

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_ready = grant;
    assign alu_busy  = any_grant;
    assign grant_id  = grant_idx;

    always_comb begin
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op.a      = req_a[slice_lo(i, XLEN) +: XLEN];
                sel_op.b      = req_b[slice_lo(i, XLEN) +: XLEN];
                sel_op.funct3 = req_funct3[slice_lo(i, 3) +: 3];
                sel_op.funct7 = req_funct7[i];
            end
        end
    end

    // With no grant sel_op is all-zero, so the ALU sees an idle ADD of zeros.
    assign alu_a      = sel_op.a;
    assign alu_b      = condition_b(sel_op.funct3, sel_op.b);
    assign alu_funct3 = sel_op.funct3;
    assign alu_funct7 = sel_op.funct7;

    // NOTE: state updates use non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order. The response
    // buffers are reset too, since their contents are visible on the ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid    <= '0;
            rsp_result   <= '0;
            rsp_tag      <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    rsp_valid[i]                          <= 1'b1;
                    rsp_result[slice_lo(i, XLEN) +: XLEN] <= alu_result;
                    rsp_tag[slice_lo(i, TAG_W) +: TAG_W]  <= req_tag[slice_lo(i, TAG_W) +: TAG_W];
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
            if (any_grant) begin
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (conflict && (conflict_cnt != 32'hFFFF_FFFF)) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational ALU between NUM_REQ requesters (e.g. execute stage, address generator, multi-cycle helper).
- Accepts operations over per-requester valid/ready and drives the ALU operand/selector ports.
- Captures the ALU result into a per-requester one-entry response buffer and returns it over a valid/ready response channel.
- Also conditions shift amounts and counts contention.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TAG_W, 4, width of the opaque tag echoed with each result.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  operation offered, one bit per requester.
- req_ready  out  NUM_REQ  operation accepted this cycle; one-hot or zero.
- req_a  in  NUM_REQ*32  operand A per requester; requester i is at [32*i+31:32*i].
- req_b  in  NUM_REQ*32  operand B per requester.
- req_funct3  in  NUM_REQ*3  operation selector 1 per requester.
- req_funct7  in  NUM_REQ  operation selector 2 per requester.
- req_tag  in  NUM_REQ*TAG_W  tag per requester.
- rsp_valid  out  NUM_REQ  result available per requester.
- rsp_ready  in  NUM_REQ  requester consumes result.
- rsp_result  out  NUM_REQ*32  buffered result per requester.
- rsp_tag  out  NUM_REQ*TAG_W  tag echoed with the result.
- alu_a  out  32  to shared ALU operand A.
- alu_b  out  32  to shared ALU operand B (shift-masked).
- alu_funct3  out  3  to shared ALU.
- alu_funct7  out  1  to shared ALU.
- alu_result  in  32  from shared ALU, combinational.
- alu_busy  out  1  ALU driven by a granted op this cycle.
- grant_id  out  2  index of the granted requester; valid only when alu_busy=1.
- conflict_cnt  out  32  cycles with more than one eligible requester.

Behaviour:
Eligibility
- eligible[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]).
- The response slot must be free, or draining in the same cycle.

Arbitration
- Combinational round-robin over eligible, searching from rr_ptr upward with wrap-around.
- At most one grant per cycle. req_ready = grant, one-hot.
- req_ready may depend on req_valid; requesters must not make valid depend on ready.
- Once asserted, req_valid and its payload are held until accepted.

Pointer update
- On a grant to index g: rr_ptr <= (g+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
- With no grant, rr_ptr is unchanged.

ALU drive
- alu_* come from the granted requester's payload, passed through unchanged except as below.
- Shift masking: if funct3 is 001 or 101, alu_b = {27'b0, req_b[4:0]}; otherwise alu_b = req_b.
- With no grant: alu_a = alu_b = 0, alu_funct3 = 000, alu_funct7 = 0, alu_busy = 0.
- Undefined funct3 codes are forwarded unchanged; the result is whatever the ALU returns.

Latency and buffering
- Accept in cycle t; rsp_result/rsp_tag load from alu_result/req_tag at the end of t; rsp_valid = 1 in cycle t+1.
- Total throughput is 1 op/cycle across all requesters.

Response handshake
- rsp_valid[i] falls after rsp_ready[i] when no new result lands in that slot the same cycle.
- Simultaneous drain and new grant on slot i: the slot is overwritten, rsp_valid[i] stays 1, and the new data appears at t+1.
- rsp_result and rsp_tag are stable while rsp_valid && !rsp_ready.

Contention counter
- conflict_cnt increments in any cycle where popcount(eligible) >= 2.
- Saturates at 32'hFFFF_FFFF.

Reset
- Asynchronous and immediate: rsp_valid = 0, rsp_result = 0, rsp_tag = 0, rr_ptr = 0, conflict_cnt = 0.
- Reset mid-operation discards buffered results.
- req_ready and alu_busy are combinational and are 0 while rsp_valid = 0 and req_valid = 0.

Decomposition:
- Package alu_share_pkg holds:
  - FUNCT3_ADD=000, SLL=001, AND=010, OR=011, XOR=100, SR=101;
  - SHAMT_W=5;
  - localparams for the flattened-slice width helpers.
- One sub-module: rr_arbiter (eligible vector, rr_ptr in -> one-hot grant, grant index out). It is purely combinational; rr_ptr is kept in the top.

Test Plan:
1. Single requester 0: a=5, b=3, funct3=000, funct7=1, tag=2 → req_ready[0]=1 in cycle 0; alu_b=3; rsp_valid[0]=1 in cycle 1 with result 2, tag 2.
2. Shift masking: a=1, b=32'h0000_0024, funct3=001 → alu_b=4, result 16. With funct3=010 (AND), alu_b=32'h24 is passed unmasked.
3. Both requesters valid every cycle, rsp_ready=1: grants alternate 0,1,0,1 from reset; conflict_cnt increments once per cycle; each requester sees one result every 2 cycles.
4. Back-pressure: rsp_ready[1]=0 holding result 7; requester 1 offers a new op → not granted and stays pending while requester 0 is served. Raise rsp_ready[1] → grant in that same cycle; new result at the next cycle with rsp_valid[1] continuously 1.
5. Reset asserted mid-stream with rsp_valid=2'b11 → outputs clear immediately (asynchronously); after release, the first grant goes to requester 0.
6. NUM_REQ=3 with eligible=3'b101 and rr_ptr=1 → grant 2, then rr_ptr=0, next grant 0; a requester that is never eligible is skipped with no stall cycle.
